// File: rtl/h_secded_dec_pipe.sv
// ---------------------------------------------------------------------------
// h_secded_dec_pipe
//   Two-stage pipelined extended-Hamming (SECDED) decoder for full-length
//   codes of N = 2**P_R bits carrying K = N-P_R-1 data bits. Placed between
//   a read port and its consumer with valid/ready on both sides. Corrects
//   single-bit errors, flags double-bit errors, reports the corrected bit
//   index and keeps saturating counters of corrected/uncorrectable words.
//
//   Codeword layout: bit 0 overall parity, bits 1,2,4,.. Hamming checks,
//   data bits in the remaining positions ascending (data[0] at bit 3).
//
// Ports
//   i_Clk        clock, rising edge
//   i_Rst        synchronous active-high reset, highest priority
//   i_Valid      input codeword valid
//   o_Ready      decoder accepts a codeword this cycle
//   i_CodeWord   received codeword (N bits)
//   o_Valid      decoded result valid
//   i_Ready      consumer accepts the result this cycle
//   o_DecodWord  decoded / corrected data (K bits)
//   o_ErrorC     single error corrected
//   o_ErrorD     uncorrectable error detected
//   o_ErrPos     codeword index that was corrected, 0 otherwise
//   i_CntClr     synchronous clear of both counters
//   o_CntC       saturating count of corrected words delivered
//   o_CntD       saturating count of uncorrectable words delivered
// ---------------------------------------------------------------------------
module h_secded_dec_pipe #(
  parameter int  P_R     = 5,
  parameter int  P_CNT_W = 16,
  localparam int N       = 2**P_R,
  localparam int K       = N - P_R - 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Valid,
  output logic               o_Ready,
  input  logic [N-1:0]       i_CodeWord,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [K-1:0]       o_DecodWord,
  output logic               o_ErrorC,
  output logic               o_ErrorD,
  output logic [P_R-1:0]     o_ErrPos,
  input  logic               i_CntClr,
  output logic [P_CNT_W-1:0] o_CntC,
  output logic [P_CNT_W-1:0] o_CntD
);

  // XOR of the indices of every set bit in positions 1..N-1.
  function automatic logic [P_R-1:0] calc_syndrome(input logic [N-1:0] cw);
    logic [P_R-1:0] s;
    s = '0;
    for (int i = 1; i < N; i++) begin
      if (cw[i]) s = s ^ P_R'(i);
    end
    return s;
  endfunction

  // Gather the non-power-of-two positions (from bit 3 upward) into data.
  function automatic logic [K-1:0] extract_data(input logic [N-1:0] cw);
    logic [K-1:0] d;
    int           j;
    d = '0;
    j = 0;
    for (int i = 3; i < N; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] c);
    if (&c) return c;
    return c + P_CNT_W'(1);
  endfunction

  // One advance enable for the whole pipe: it moves whenever the output
  // register is empty or is being drained this cycle.
  logic adv_en;
  logic xfer_out;

  logic           vld_p1_q;
  logic [N-1:0]   cw_p1_q;
  logic [P_R-1:0] syn_p1_q;
  logic           par_p1_q;

  logic           vld_p2_q;
  logic [K-1:0]   data_p2_q, data_p2_d;
  logic           errc_p2_q, errc_p2_d;
  logic           errd_p2_q, errd_p2_d;
  logic [P_R-1:0] pos_p2_q, pos_p2_d;
  logic [N-1:0]   corr_cw;

  logic [P_CNT_W-1:0] cnt_c_q, cnt_c_d;
  logic [P_CNT_W-1:0] cnt_d_q, cnt_d_d;

  assign adv_en   = !vld_p2_q || i_Ready;
  assign o_Ready  = adv_en;
  assign xfer_out = vld_p2_q && i_Ready;

  // ---- stage 1: capture codeword, syndrome and overall parity ----
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vld_p1_q <= 1'b0;
    end else if (adv_en) begin
      vld_p1_q <= i_Valid;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (adv_en) begin
      cw_p1_q  <= i_CodeWord;
      syn_p1_q <= calc_syndrome(i_CodeWord);
      par_p1_q <= ^i_CodeWord;
    end
  end

  // Odd overall parity means exactly one flipped bit, located at the
  // syndrome (syndrome 0 points at the parity bit itself). Even parity with
  // a nonzero syndrome is an uncorrectable pair; data passes through as is.
  always_comb begin
    corr_cw = cw_p1_q;
    if (par_p1_q) corr_cw[syn_p1_q] = ~cw_p1_q[syn_p1_q];
    data_p2_d = extract_data(corr_cw);
    errc_p2_d = par_p1_q;
    errd_p2_d = !par_p1_q && (syn_p1_q != '0);
    pos_p2_d  = par_p1_q ? syn_p1_q : '0;
  end

  // ---- stage 2: corrected data and error flags ----
  // Result registers only reload on a real word, so a bubble leaves the last
  // result parked behind o_Valid=0.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      errc_p2_q <= 1'b0;
      errd_p2_q <= 1'b0;
      pos_p2_q  <= '0;
    end else if (adv_en) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        data_p2_q <= data_p2_d;
        errc_p2_q <= errc_p2_d;
        errd_p2_q <= errd_p2_d;
        pos_p2_q  <= pos_p2_d;
      end
    end
  end

  // Counters advance only when a flagged word is actually handed over;
  // a clear request overrides a simultaneous increment.
  always_comb begin
    cnt_c_d = cnt_c_q;
    cnt_d_d = cnt_d_q;
    if (i_CntClr) begin
      cnt_c_d = '0;
      cnt_d_d = '0;
    end else if (xfer_out) begin
      if (errc_p2_q) cnt_c_d = sat_inc(cnt_c_q);
      if (errd_p2_q) cnt_d_d = sat_inc(cnt_d_q);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_c_q <= '0;
      cnt_d_q <= '0;
    end else begin
      cnt_c_q <= cnt_c_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  assign o_Valid     = vld_p2_q;
  assign o_DecodWord = data_p2_q;
  assign o_ErrorC    = errc_p2_q;
  assign o_ErrorD    = errd_p2_q;
  assign o_ErrPos    = pos_p2_q;
  assign o_CntC      = cnt_c_q;
  assign o_CntD      = cnt_d_q;

endmodule

// File: tb/tb_h_secded_dec_pipe.sv
// ---------------------------------------------------------------------------
// tb_h_secded_dec_pipe
//   Directed bench for h_secded_dec_pipe: a 32/26 instance with 4-bit
//   counters, plus 8/4 and 64/57 instances. Expected values are hand-derived
//   codeword decodes.
// ---------------------------------------------------------------------------
module tb_h_secded_dec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  // 32/26 instance, 4-bit counters
  logic        a_v, a_rdy, a_clr, a_ordy, a_ov, a_c, a_d;
  logic [31:0] a_cw;
  logic [25:0] a_data;
  logic [4:0]  a_pos;
  logic [3:0]  a_cntc, a_cntd;

  // 8/4 instance
  logic        b_v, b_ordy, b_ov, b_c, b_d;
  logic [7:0]  b_cw;
  logic [3:0]  b_data;
  logic [2:0]  b_pos;
  logic [15:0] b_cntc, b_cntd;

  // 64/57 instance
  logic        c_v, c_ordy, c_ov, c_c, c_d;
  logic [63:0] c_cw;
  logic [56:0] c_data;
  logic [5:0]  c_pos;
  logic [15:0] c_cntc, c_cntd;

  logic bc_rdy = 1'b1;
  logic bc_clr = 1'b0;

  h_secded_dec_pipe #(.P_R(5), .P_CNT_W(4)) u_a (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(a_v), .o_Ready(a_ordy),
    .i_CodeWord(a_cw), .o_Valid(a_ov), .i_Ready(a_rdy),
    .o_DecodWord(a_data), .o_ErrorC(a_c), .o_ErrorD(a_d), .o_ErrPos(a_pos),
    .i_CntClr(a_clr), .o_CntC(a_cntc), .o_CntD(a_cntd)
  );

  h_secded_dec_pipe #(.P_R(3)) u_b (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(b_v), .o_Ready(b_ordy),
    .i_CodeWord(b_cw), .o_Valid(b_ov), .i_Ready(bc_rdy),
    .o_DecodWord(b_data), .o_ErrorC(b_c), .o_ErrorD(b_d), .o_ErrPos(b_pos),
    .i_CntClr(bc_clr), .o_CntC(b_cntc), .o_CntD(b_cntd)
  );

  h_secded_dec_pipe #(.P_R(6)) u_c (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(c_v), .o_Ready(c_ordy),
    .i_CodeWord(c_cw), .o_Valid(c_ov), .i_Ready(bc_rdy),
    .o_DecodWord(c_data), .o_ErrorC(c_c), .o_ErrorD(c_d), .o_ErrPos(c_pos),
    .i_CntClr(bc_clr), .o_CntC(c_cntc), .o_CntD(c_cntd)
  );

  // Stream vectors for the 32/26 instance
  logic [31:0] sv  [8] = '{32'h0, 32'hFFFF_FFFF, 32'h33, 32'h8,
                           32'h1, 32'h7FFF_FFFF, 32'h18, 32'h13};
  logic [25:0] se_dat [8] = '{26'h0, 26'h3FF_FFFF, 26'h2, 26'h0,
                              26'h0, 26'h3FF_FFFF, 26'h1, 26'h2};
  logic        se_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        se_d [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [4:0]  se_p [8] = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd31, 5'd0, 5'd5};

  // 8/4 vectors
  logic [7:0] bv  [7] = '{8'hFF, 8'h08, 8'h01, 8'h7F, 8'h18, 8'hAA, 8'hEA};
  logic [3:0] bdt [7] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h1, 4'hB, 4'hB};
  logic       bcf [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       bdf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0] bps [7] = '{3'd0, 3'd3, 3'd0, 3'd7, 3'd0, 3'd0, 3'd6};

  // 64/57 vectors
  logic [63:0] cv  [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 64'h1,
                           64'h7FFF_FFFF_FFFF_FFFF, 64'h18, 64'h33, 64'h13};
  logic [56:0] cdt [7] = '{57'h1FF_FFFF_FFFF_FFFF, 57'h0, 57'h0,
                           57'h1FF_FFFF_FFFF_FFFF, 57'h1, 57'h2, 57'h2};
  logic        ccf [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        cdf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [5:0]  cps [7] = '{6'd0, 6'd3, 6'd0, 6'd63, 6'd0, 6'd0, 6'd5};

  int          in_idx, out_idx;
  logic        in_x, was_stall;
  logic [25:0] held_data;
  logic [4:0]  held_pos;
  logic        held_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs to the 32/26 instance, then advance to the next falling edge.
  task automatic a_drive(input logic v, input logic [31:0] cw);
    a_v  = v;
    a_cw = cw;
    @(negedge clk);
  endtask

  task automatic a_chk(input string tag, input logic [25:0] dat, input logic ec,
                       input logic ed, input logic [4:0] pos);
    chk({tag, ".valid"}, a_ov, 1'b1);
    chk({tag, ".data"}, a_data, dat);
    chk({tag, ".errc"}, a_c, ec);
    chk({tag, ".errd"}, a_d, ed);
    chk({tag, ".pos"}, a_pos, pos);
  endtask

  initial begin
    rst = 1'b1;
    a_v = 1'b0; a_cw = '0; a_rdy = 1'b1; a_clr = 1'b0;
    b_v = 1'b0; b_cw = '0;
    c_v = 1'b0; c_cw = '0;
    was_stall = 1'b0;
    held_data = '0; held_pos = '0; held_c = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.valid", a_ov, 1'b0);
    chk("rst.ready", a_ordy, 1'b1);
    chk("rst.data", a_data, 26'h0);
    chk("rst.errc", a_c, 1'b0);
    chk("rst.errd", a_d, 1'b0);
    chk("rst.pos", a_pos, 5'd0);
    chk("rst.cntc", a_cntc, 4'd0);
    chk("rst.cntd", a_cntd, 4'd0);
    chk("rst.b_valid", b_ov, 1'b0);
    chk("rst.c_valid", c_ov, 1'b0);

    // Clean words
    a_drive(1'b1, 32'h0);
    a_drive(1'b1, 32'hFFFF_FFFF);
    a_chk("t1.zero", 26'h0, 1'b0, 1'b0, 5'd0);
    a_drive(1'b0, '0);
    a_chk("t1.ones", 26'h3FF_FFFF, 1'b0, 1'b0, 5'd0);
    a_drive(1'b0, '0);
    chk("t1.idle", a_ov, 1'b0);
    chk("t1.cntc", a_cntc, 4'd0);
    chk("t1.cntd", a_cntd, 4'd0);

    // Single errors: data bit, parity bit, top bit
    a_drive(1'b1, 32'h8);
    a_drive(1'b1, 32'h1);
    a_chk("t2.bit3", 26'h0, 1'b1, 1'b0, 5'd3);
    a_drive(1'b1, 32'h7FFF_FFFF);
    a_chk("t2.bit0", 26'h0, 1'b1, 1'b0, 5'd0);
    a_drive(1'b0, '0);
    a_chk("t2.bit31", 26'h3FF_FFFF, 1'b1, 1'b0, 5'd31);
    a_drive(1'b0, '0);
    chk("t2.cntc", a_cntc, 4'd3);
    chk("t2.cntd", a_cntd, 4'd0);

    // Double error, then a clean word with data in a middle position
    a_drive(1'b1, 32'h18);
    a_drive(1'b1, 32'h33);
    a_chk("t3.double", 26'h1, 1'b0, 1'b1, 5'd0);
    a_drive(1'b1, 32'h13);
    a_chk("t3.clean33", 26'h2, 1'b0, 1'b0, 5'd0);
    a_drive(1'b0, '0);
    a_chk("t3.bit5", 26'h2, 1'b1, 1'b0, 5'd5);
    a_drive(1'b0, '0);
    chk("t3.cntd", a_cntd, 4'd1);
    chk("t3.cntc", a_cntc, 4'd4);

    // Back-to-back stream with a 3-cycle consumer stall
    in_idx = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      a_rdy = !(cyc >= 4 && cyc < 7);
      a_v   = (in_idx < 8);
      a_cw  = (in_idx < 8) ? sv[in_idx] : 32'h0;
      #1;
      if (a_ov && !a_rdy) begin
        chk("t4.ready_low", a_ordy, 1'b0);
        if (was_stall) begin
          chk("t4.hold_data", a_data, held_data);
          chk("t4.hold_pos", a_pos, held_pos);
          chk("t4.hold_errc", a_c, held_c);
        end
        held_data = a_data;
        held_pos  = a_pos;
        held_c    = a_c;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (a_ov && a_rdy) begin
        if (out_idx < 8) begin
          chk("t4.data", a_data, se_dat[out_idx]);
          chk("t4.errc", a_c, se_c[out_idx]);
          chk("t4.errd", a_d, se_d[out_idx]);
          chk("t4.pos", a_pos, se_p[out_idx]);
        end
        out_idx++;
      end
      in_x = a_v && a_ordy;
      @(posedge clk);
      if (in_x) in_idx++;
      @(negedge clk);
    end
    a_rdy = 1'b1;
    a_v   = 1'b0;
    chk("t4.in_count", in_idx, 8);
    chk("t4.out_count", out_idx, 8);
    chk("t4.drained", a_ov, 1'b0);
    chk("t4.cntc", a_cntc, 4'd8);
    chk("t4.cntd", a_cntd, 4'd2);

    // Saturation of the 4-bit corrected counter
    for (int i = 0; i < 20; i++) begin
      a_v  = 1'b1;
      a_cw = 32'h8;
      @(negedge clk);
    end
    a_v = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5.sat", a_cntc, 4'd15);
    chk("t5.cntd", a_cntd, 4'd2);
    a_drive(1'b1, 32'h8);
    a_drive(1'b0, '0);
    a_chk("t5.last", 26'h0, 1'b1, 1'b0, 5'd3);
    a_clr = 1'b1;
    a_drive(1'b0, '0);
    a_clr = 1'b0;
    chk("t5.clr_c", a_cntc, 4'd0);
    chk("t5.clr_d", a_cntd, 4'd0);

    // Reset with two words in flight
    a_drive(1'b1, 32'h8);
    a_drive(1'b1, 32'h1);
    chk("t6.inflight", a_ov, 1'b1);
    rst = 1'b1;
    a_drive(1'b0, '0);
    rst = 1'b0;
    chk("t6.valid", a_ov, 1'b0);
    chk("t6.cntc", a_cntc, 4'd0);
    chk("t6.data", a_data, 26'h0);
    chk("t6.errc", a_c, 1'b0);
    chk("t6.pos", a_pos, 5'd0);
    for (int i = 0; i < 3; i++) begin
      a_drive(1'b0, '0);
      chk("t6.stale", a_ov, 1'b0);
    end
    chk("t6.cntc_after", a_cntc, 4'd0);

    // 8/4 and 64/57 codes, pipelined at full rate
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin
        b_v = 1'b1; b_cw = bv[i];
        c_v = 1'b1; c_cw = cv[i];
      end else begin
        b_v = 1'b0; b_cw = '0;
        c_v = 1'b0; c_cw = '0;
      end
      @(negedge clk);
      if (i >= 1 && i <= 7) begin
        chk("r3.valid", b_ov, 1'b1);
        chk("r3.data", b_data, bdt[i-1]);
        chk("r3.errc", b_c, bcf[i-1]);
        chk("r3.errd", b_d, bdf[i-1]);
        chk("r3.pos", b_pos, bps[i-1]);
        chk("r6.valid", c_ov, 1'b1);
        chk("r6.data", c_data, cdt[i-1]);
        chk("r6.errc", c_c, ccf[i-1]);
        chk("r6.errd", c_d, cdf[i-1]);
        chk("r6.pos", c_pos, cps[i-1]);
      end
    end
    chk("r3.idle", b_ov, 1'b0);
    chk("r3.cntc", b_cntc, 16'd4);
    chk("r3.cntd", b_cntd, 16'd1);
    chk("r6.idle", c_ov, 1'b0);
    chk("r6.cntc", c_cntc, 16'd4);
    chk("r6.cntd", c_cntd, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
